cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against the current flags.
- Gates the decoder's PCS/RegW/MemW into the final PCSrc/RegWrite/MemWrite strobes.
- Updates the flag groups requested by FlagW, but only when the instruction actually executes.

Parameters:
- FLAG_W, 4, width of flag register {N,Z,C,V}; fixed at 4, exposed only for the shared package.
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  from decoder; [1] writes N,Z; [0] writes C,V.
- PCS  input  1  from decoder; instruction writes PC.
- RegW  input  1  from decoder; instruction writes register file.
- MemW  input  1  from decoder; instruction writes data memory.
- PCSrc  output  1  PCS & CondEx.
- RegWrite  output  1  RegW & CondEx.
- MemWrite  output  1  MemW & CondEx.
- CondEx  output  1  condition passed for the current instruction.

Behaviour:
- Flags register: 4 bits {N,Z,C,V}, reset to RESET_FLAGS asynchronously while reset=0.
- Combinational path: CondEx, PCSrc, RegWrite and MemWrite are combinational from Cond, the registered flags and the decoder inputs. Zero-cycle latency.
- During reset the registered flags equal RESET_FLAGS and the outputs follow them. With RESET_FLAGS=0, Cond=AL gives CondEx=1.
- Condition table, evaluated on registered flags only (never ALUFlags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1.
  - 1111 is unconditional-reserved and evaluates to 0 (squash).
- Flag update on the rising clk edge:
  - if FlagW[1] & CondEx: N,Z <= ALUFlags[3:2].
  - if FlagW[0] & CondEx: C,V <= ALUFlags[1:0].
  - Groups update independently. FlagW=10 (logical op with S) leaves C,V unchanged.
- A squashed instruction (CondEx=0) changes no flags and asserts no write strobe, whatever the decoder drives.
- Back-to-back instructions: the instruction in cycle n+1 sees flags written at the end of cycle n. There is no same-cycle bypass.
- Reset asserted mid-operation: flags return to RESET_FLAGS immediately. No pending update survives reset release. The first edge after release applies normal update rules.
- Decoder drives X on inputs for an undefined Op: outputs are don't-care, but flags must not change unless CondEx=1 and FlagW≠00 resolve to known values. The bench checks known inputs only.

Optional Feature:
- Macro COND_LOGIC_DEBUG_EN.
- When defined, two extra outputs are added:
  - FlagsOut (4): the registered NZCV.
  - SquashCount (16): counts cycles with CondEx=0 while any of PCS/RegW/MemW/FlagW is nonzero. Resets to 0. Saturates at 16'hFFFF with no wrap.
- When undefined, neither port nor counter exists and the interface is exactly as listed above.

Decomposition:
- Shared package arm_pkg:
  - condition-code localparams COND_EQ..COND_AL.
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW bit meanings.
- Sub-module cond_check: purely combinational Cond x Flags -> CondEx. Reusable by a future pipelined hazard unit.
- cond_logic instantiates cond_check and holds the flag register, the gating and the optional counter.

Test Plan:
- Reset: reset=0, then release with Cond=1110, RegW=1 -> CondEx=1, RegWrite=1, flags=0000 (FlagsOut under debug).
- SUBS then BEQ:
  - Cycle 1: Cond=AL, FlagW=11, ALUFlags=0110 -> flags become 0110 after the edge.
  - Cycle 2: Cond=0000, PCS=1 -> PCSrc=1.
  - Cycle 2 with Cond=0001 instead -> PCSrc=0.
- Group independence: flags=0011; ANDS with FlagW=10, ALUFlags=1000 -> flags=1011 (C,V kept).
- Squash:
  - flags=0100 (Z=1), Cond=0001 (NE), RegW=1, MemW=1, FlagW=11, ALUFlags=1111 -> RegWrite=0, MemWrite=0, flags stay 0100.
  - Under debug, SquashCount increments by 1.
- Signed compares:
  - flags N=1,V=0: GE -> 0, LT -> 1, GT -> 0, LE -> 1.
  - flags N=1,V=1,Z=0: GT -> 1. Also cover HI/LS with C=1,Z=0 -> HI=1, LS=0.
- Async reset mid-run: flags=1111, drop reset between edges -> flags=0000 without a clock edge. Cond=0000 then gives CondEx=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Purpose: shared constants for the ARM conditional-execution logic (condition codes, flag bit indices, FlagW bit meanings).
// Latency: n/a (constants only).
// Backpressure: n/a.
package arm_pkg;

    // Width of the architectural flag register {N,Z,C,V}; fixed at 4.
    localparam int FLAG_W = 4;

    // Default NZCV value loaded on reset.
    localparam logic [FLAG_W-1:0] RESET_FLAGS_DEF = 4'b0000;

    // Flag bit positions inside the NZCV vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW bit meanings: [1] writes the N,Z group, [0] writes the C,V group.
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    // Instruction condition field encodings (Instr[31:28]).
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    // Unconditional-reserved space: treated as a squash in this datapath.
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_check.sv
// Purpose: evaluates a 4-bit ARM condition field against an NZCV flag vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   cond    - instruction condition field
//   flags   - {N,Z,C,V} to test against
//   cond_ex - 1 when the condition passes
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // COND_NV squashes
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Purpose: conditional-execution stage; holds NZCV, gates decoder write strobes, updates flags on executed instructions.
// Latency: strobes/CondEx combinational (zero cycles); flag updates visible to the next instruction.
// Backpressure: none; one instruction per cycle.
//
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   Cond         - instruction condition field
//   ALUFlags     - {N,Z,C,V} produced by the ALU this cycle
//   FlagW        - decoder flag-write request ([1] N,Z; [0] C,V)
//   PCS/RegW/MemW - decoder write requests
//   PCSrc/RegWrite/MemWrite - gated write strobes
//   CondEx       - condition passed
//   FlagsOut, SquashCount - debug outputs, present only with COND_LOGIC_DEBUG_EN defined
module cond_logic
    import arm_pkg::*;
#(
    parameter logic [FLAG_W-1:0] RESET_FLAGS = RESET_FLAGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              CondEx
`ifdef COND_LOGIC_DEBUG_EN
    ,
    output logic [FLAG_W-1:0] FlagsOut,
    output logic [15:0]       SquashCount
`endif
);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cond_ex;

    // Conditions always see the registered flags, so an instruction never
    // observes the flags its own ALU result is producing.
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS  & cond_ex;
    assign RegWrite = RegW & cond_ex;
    assign MemWrite = MemW & cond_ex;

    // The if-conditions only resolve true for known 1s, so an X coming from
    // the decoder on an undefined op leaves the flags untouched.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && FlagW[FLAGW_NZ]) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (cond_ex && FlagW[FLAGW_CV]) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= RESET_FLAGS;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef COND_LOGIC_DEBUG_EN
    logic [15:0] squash_cnt_q, squash_cnt_d;
    logic        squash_evt;

    // A squash only counts when the decoder actually wanted to do something.
    assign squash_evt = ~cond_ex & (PCS | RegW | MemW | (|FlagW));

    always_comb begin
        squash_cnt_d = squash_cnt_q;
        if (squash_evt && (squash_cnt_q != 16'hFFFF)) begin
            squash_cnt_d = squash_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            squash_cnt_q <= 16'd0;
        end else begin
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign FlagsOut    = flags_q;
    assign SquashCount = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs, reg_w, mem_w;
    logic       pc_src, reg_write, mem_write, cond_ex;
`ifdef COND_LOGIC_DEBUG_EN
    logic [3:0]  flags_out;
    logic [15:0] squash_cnt;
    logic [15:0] cnt0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference flag state and scoreboard of {CondEx,PCSrc,RegWrite,MemWrite}.
    logic [3:0] flags_m;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    logic [3:0] e, o, f;

    always #5 clk = ~clk;

    cond_logic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (cond),
        .ALUFlags (alu_flags),
        .FlagW    (flag_w),
        .PCS      (pcs),
        .RegW     (reg_w),
        .MemW     (mem_w),
        .PCSrc    (pc_src),
        .RegWrite (reg_write),
        .MemWrite (mem_write),
        .CondEx   (cond_ex)
`ifdef COND_LOGIC_DEBUG_EN
        ,
        .FlagsOut    (flags_out),
        .SquashCount (squash_cnt)
`endif
    );

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] fl);
        logic n, z, cf, v;
        n = fl[3]; z = fl[2]; cf = fl[1]; v = fl[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one instruction, record expected and observed strobes, then clock it.
    task automatic step(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                        input logic p, input logic r, input logic m);
        logic ce;
        cond = c; alu_flags = a; flag_w = fw; pcs = p; reg_w = r; mem_w = m;
        ce = ref_cond(c, flags_m);
        exp_q.push_back({ce, p & ce, r & ce, m & ce});
        #1;
        obs_q.push_back({cond_ex, pc_src, reg_write, mem_write});
        @(posedge clk);
        #1;
        if (reset && ce && fw[1]) flags_m[3:2] = a[3:2];
        if (reset && ce && fw[0]) flags_m[1:0] = a[1:0];
        flag_w = 2'b00; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    endtask

    // Reads back the registered flags through the condition evaluator (4 time units, no clock edge).
    task automatic probe(output logic [3:0] fl);
        flag_w = 2'b00; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
        cond = 4'h0; #1; fl[2] = cond_ex;
        cond = 4'h2; #1; fl[1] = cond_ex;
        cond = 4'h4; #1; fl[3] = cond_ex;
        cond = 4'h6; #1; fl[0] = cond_ex;
    endtask

    task automatic test_reset;
        reset = 1'b0; cond = 4'hE; alu_flags = 4'h0; flag_w = 2'b00;
        pcs = 1'b0; reg_w = 1'b1; mem_w = 1'b0;
        flags_m = 4'b0000;
        #2;
        n_tests++;
        if (cond_ex !== 1'b1) begin
            n_fail++; $display("FAIL reset_condex got %b want 1", cond_ex);
        end
        n_tests++;
        if (reg_write !== 1'b1) begin
            n_fail++; $display("FAIL reset_regwrite got %b want 1", reg_write);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (cond_ex !== 1'b1 || reg_write !== 1'b1) begin
            n_fail++; $display("FAIL release_al got %b%b want 11", cond_ex, reg_write);
        end
        probe(f);
        n_tests++;
        if (f !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", f);
        end
`ifdef COND_LOGIC_DEBUG_EN
        n_tests++;
        if (flags_out !== 4'b0000 || squash_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_debug got %b/%0d want 0000/0", flags_out, squash_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_subs_beq;
        step(4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0);     // SUBS
        probe(f);
        n_tests++;
        if (f !== 4'b0110) begin
            n_fail++; $display("FAIL subs_flags got %b want 0110", f);
        end
        step(4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);     // BEQ taken
        n_tests++;
        if (obs_q[obs_q.size()-1][2] !== 1'b1) begin
            n_fail++; $display("FAIL beq_pcsrc got %b want 1", obs_q[obs_q.size()-1][2]);
        end
        step(4'h1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);     // BNE not taken
        n_tests++;
        if (obs_q[obs_q.size()-1][2] !== 1'b0) begin
            n_fail++; $display("FAIL bne_pcsrc got %b want 0", obs_q[obs_q.size()-1][2]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL subs_beq_sb got %b want %b", o, e); end
        end
    endtask

    task automatic test_group_indep;
        step(4'hE, 4'b0011, 2'b11, 1'b0, 1'b0, 1'b0);
        step(4'hE, 4'b1000, 2'b10, 1'b0, 1'b1, 1'b0);     // ANDS: N,Z only
        probe(f);
        n_tests++;
        if (f !== 4'b1011) begin
            n_fail++; $display("FAIL group_flags got %b want 1011", f);
        end
        step(4'hE, 4'b0100, 2'b01, 1'b0, 1'b0, 1'b0);     // C,V only
        probe(f);
        n_tests++;
        if (f !== 4'b1000) begin
            n_fail++; $display("FAIL group_cv got %b want 1000", f);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL group_sb got %b want %b", o, e); end
        end
    endtask

    task automatic test_squash;
        step(4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
`ifdef COND_LOGIC_DEBUG_EN
        cnt0 = squash_cnt;
`endif
        step(4'h1, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);     // NE with Z=1: squashed
        n_tests++;
        if (obs_q[obs_q.size()-1] !== 4'b0000) begin
            n_fail++; $display("FAIL squash_strobes got %b want 0000", obs_q[obs_q.size()-1]);
        end
        probe(f);
        n_tests++;
        if (f !== 4'b0100) begin
            n_fail++; $display("FAIL squash_flags got %b want 0100", f);
        end
`ifdef COND_LOGIC_DEBUG_EN
        n_tests++;
        if (squash_cnt !== cnt0 + 16'd1) begin
            n_fail++; $display("FAIL squash_count got %0d want %0d", squash_cnt, cnt0 + 16'd1);
        end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL squash_sb got %b want %b", o, e); end
        end
    endtask

    task automatic test_signed;
        logic [3:0] want;
        step(4'hE, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0);     // N=1, V=0
        want = 4'b0101;                                   // GE,LT,GT,LE
        for (int i = 0; i < 4; i++) begin
            step(4'hA + 4'(i), 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_q[obs_q.size()-1][3] !== want[3-i]) begin
                n_fail++; $display("FAIL signed_nv10 cond=%h got %b want %b", 4'hA + 4'(i),
                                   obs_q[obs_q.size()-1][3], want[3-i]);
            end
        end
        step(4'hE, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0);     // N=1, V=1, Z=0
        step(4'hC, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_q[obs_q.size()-1][3] !== 1'b1) begin
            n_fail++; $display("FAIL signed_gt got %b want 1", obs_q[obs_q.size()-1][3]);
        end
        step(4'hE, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0);     // C=1, Z=0
        step(4'h8, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
        step(4'h9, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
        step(4'hF, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);     // reserved: squash
        n_tests++;
        if (obs_q[obs_q.size()-3][3] !== 1'b1 || obs_q[obs_q.size()-2][3] !== 1'b0 ||
            obs_q[obs_q.size()-1] !== 4'b0000) begin
            n_fail++; $display("FAIL hi_ls_nv got %b/%b/%b want 1/0/0000", obs_q[obs_q.size()-3][3],
                               obs_q[obs_q.size()-2][3], obs_q[obs_q.size()-1]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL signed_sb got %b want %b", o, e); end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 60; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_sb got %b want %b", o, e); end
        end
        probe(f);
        n_tests++;
        if (f !== flags_m) begin
            n_fail++; $display("FAIL b2b_flags got %b want %b", f, flags_m);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        step(4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0);
        probe(f);
        n_tests++;
        if (f !== 4'b1111) begin
            n_fail++; $display("FAIL pre_reset_flags got %b want 1111", f);
        end
        @(posedge clk); #3;
        reset = 1'b0;                                     // between edges
        #1;
        probe(f);
        n_tests++;
        if (f !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset_flags got %b want 0000", f);
        end
        cond = 4'h0; #1;
        n_tests++;
        if (cond_ex !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_eq got %b want 0", cond_ex);
        end
        flags_m = 4'b0000;
        @(posedge clk); #1;
        step(4'hE, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0);     // ignored while in reset
        reset = 1'b1;
        #1;
        probe(f);
        n_tests++;
        if (f !== 4'b0000) begin
            n_fail++; $display("FAIL release_no_pending got %b want 0000", f);
        end
        @(posedge clk); #1;
        step(4'hE, 4'b1010, 2'b11, 1'b0, 1'b1, 1'b0);     // first edge after release updates
        probe(f);
        n_tests++;
        if (f !== 4'b1010) begin
            n_fail++; $display("FAIL post_release_flags got %b want 1010", f);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL async_sb got %b want %b", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_subs_beq();
        test_group_indep();
        test_squash();
        test_signed();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
